// File: rtl/mem_write_checker_pkg.sv
// mem_write_checker_pkg
//   Shared types and constants for the data-memory write checker.
//   - chk_state_t : checker FSM states
//   - FAIL_*      : fail_code encodings
//   - idx_width() : index width that never collapses to zero bits
// The (addr, data) entry struct depends on the bus widths, so it is declared
// inside mem_write_checker where ADDR_W/DATA_W are known.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } chk_state_t;

  localparam logic [1:0] FAIL_NONE    = 2'd0;
  localparam logic [1:0] FAIL_DATA    = 2'd1;
  localparam logic [1:0] FAIL_ADDR    = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// mem_write_checker_if
//   Monitored data-memory write port.
//   mem_write  : write strobe
//   data_adr   : write address (ADDR_W)
//   write_data : write data (DATA_W)
//   master drives the bus (core / testbench), slave observes it (checker).
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (output mem_write, data_adr, write_data);
  modport slave  (input  mem_write, data_adr, write_data);
endinterface

// File: rtl/mem_write_checker_chk_timeout_counter.sv
// chk_timeout_counter
//   Saturating up-counter with enable, synchronous clear and expiry compare.
//   clk, reset (async, active-low)
//   en      : count this cycle
//   clr     : force count to zero (wins over en)
//   limit   : expiry value, 0 disables expiry
//   expired : the count reached on this edge equals/exceeds limit (combinational)
module chk_timeout_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] count;
  logic [W-1:0] count_inc;

  assign count_inc = (&count) ? count : count + W'(1);

  // Compare against the post-increment value so that expiry is decided on the
  // limit-th enabled edge.
  assign expired = en && (limit != '0) && (count_inc >= limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count_inc;
  end
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Watches data-memory writes and checks them, in order, against a table of
//   expected (address, data) pairs. Reports pass, or fail with the offending
//   write and a reason code. Optional cycle timeout.
//
//   Build option: MEM_WRITE_CHECKER_IGNORE_EN enables the ignored-address
//   window [IGN_LO, IGN_HI]; without it every unexpected address fails.
//
//   Ports
//     clk, reset            clock / async active-low reset
//     bus                   monitored write port (slave modport)
//     cfg_we/idx/addr/data  table write, honoured in IDLE only
//     num_active            entries to check, sampled on start (clamped 1..NUM_EXP)
//     timeout               cycle budget sampled on start, 0 = none
//     start / clear         IDLE->RUN / PASS,FAIL->IDLE
//     done, pass            result flags
//     fail_code             0 none, 1 data, 2 address, 3 timeout
//     match_count           expected writes matched so far
//     fail_addr, fail_data  the failing write
//
//   state | meaning
//   IDLE  | table programmable, waiting for start
//   RUN   | checking writes, counting cycles
//   PASS  | all active entries matched (sticky)
//   FAIL  | mismatch or timeout (sticky)
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          NUM_EXP   = 4,
  parameter int          TIMEOUT_W = 16,
  parameter int unsigned IGN_LO    = 96,
  parameter int unsigned IGN_HI    = 96,
  localparam int         IDX_W     = idx_width(NUM_EXP),
  localparam int         CNT_W     = $clog2(NUM_EXP + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_write_checker_if.slave   bus,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic [CNT_W-1:0]     num_active,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 start,
  input  logic                 clear,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           fail_code,
  output logic [CNT_W-1:0]     match_count,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_entry_t;

  chk_state_t           state;
  exp_entry_t           exp_tbl [NUM_EXP];
  exp_entry_t           cur;
  logic [CNT_W-1:0]     num_act_q;
  logic [CNT_W-1:0]     num_start;
  logic [CNT_W-1:0]     mc_inc;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic                 tmo_expired;
  logic                 in_ign;

  // match_count < num_act_q <= NUM_EXP while in RUN, so the slice is in range.
  assign cur    = exp_tbl[match_count[IDX_W-1:0]];
  assign mc_inc = match_count + CNT_W'(1);

  always_comb begin
    num_start = num_active;
    if (num_active == '0)                     num_start = CNT_W'(1);
    else if (num_active > CNT_W'(NUM_EXP))    num_start = CNT_W'(NUM_EXP);
  end

`ifdef MEM_WRITE_CHECKER_IGNORE_EN
  assign in_ign = (bus.data_adr >= ADDR_W'(IGN_LO)) && (bus.data_adr <= ADDR_W'(IGN_HI));
`else
  logic [63:0] ign_unused;
  assign ign_unused = {32'(IGN_LO), 32'(IGN_HI)};
  assign in_ign     = 1'b0;
`endif

  chk_timeout_counter #(.W(TIMEOUT_W)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .en      (state == RUN),
    .clr     (state == IDLE),
    .limit   (tmo_q),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= FAIL_NONE;
      match_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      num_act_q   <= '0;
      tmo_q       <= '0;
      for (int i = 0; i < NUM_EXP; i++) exp_tbl[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_we && (int'(cfg_idx) < NUM_EXP)) exp_tbl[cfg_idx] <= '{addr: cfg_addr, data: cfg_data};
          if (start) begin
            num_act_q   <= num_start;
            tmo_q       <= timeout;
            match_count <= '0;
            fail_code   <= FAIL_NONE;
            fail_addr   <= '0;
            fail_data   <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          if (bus.mem_write) begin
            if (bus.data_adr == cur.addr) begin
              if (bus.write_data == cur.data) begin
                match_count <= mc_inc;
                if (mc_inc == num_act_q) begin
                  state <= PASS;
                  done  <= 1'b1;
                  pass  <= 1'b1;
                end
              end else begin
                state     <= FAIL;
                done      <= 1'b1;
                fail_code <= FAIL_DATA;
                fail_addr <= bus.data_adr;
                fail_data <= bus.write_data;
              end
            end else if (!in_ign) begin
              state     <= FAIL;
              done      <= 1'b1;
              fail_code <= FAIL_ADDR;
              fail_addr <= bus.data_adr;
              fail_data <= bus.write_data;
            end
          end else if (tmo_expired) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FAIL_TIMEOUT;
          end
        end
        PASS, FAIL: begin
          if (clear) begin
            state       <= IDLE;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FAIL_NONE;
            match_count <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker
//   Directed scoreboard bench for mem_write_checker. Stimulus pushes the
//   expected result (flags, code, match count, failing write, completion
//   cycle); a monitor pops and compares on every rising edge of done.
//   Expectations for the ignore window follow MEM_WRITE_CHECKER_IGNORE_EN.
module tb_mem_write_checker;
  import mem_write_checker_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int NUM_EXP   = 4;
  localparam int TIMEOUT_W = 16;

  typedef struct {
    string       name;
    logic        pass;
    logic [1:0]  code;
    int          mc;
    logic [31:0] fa;
    logic [31:0] fd;
    longint      cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_we;
  logic [1:0]           cfg_idx;
  logic [ADDR_W-1:0]    cfg_addr;
  logic [DATA_W-1:0]    cfg_data;
  logic [2:0]           num_active;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 start;
  logic                 clear;
  logic                 done;
  logic                 pass;
  logic [1:0]           fail_code;
  logic [2:0]           match_count;
  logic [ADDR_W-1:0]    fail_addr;
  logic [DATA_W-1:0]    fail_data;

  mem_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_EXP(NUM_EXP), .TIMEOUT_W(TIMEOUT_W),
    .IGN_LO(96), .IGN_HI(96)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_active(num_active), .timeout(timeout), .start(start), .clear(clear),
    .done(done), .pass(pass), .fail_code(fail_code), .match_count(match_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   sb [$];
  longint start_cyc;

  task automatic chk(input string tn, input string fld, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d expected %0d", tn, fld, act, exp);
    end
  endtask

  function automatic void push_exp(input string tn, input logic p, input logic [1:0] code,
                                   input int mc, input logic [31:0] fa, input logic [31:0] fd,
                                   input longint c);
    exp_t e;
    e.name = tn; e.pass = p; e.code = code; e.mc = mc; e.fa = fa; e.fd = fd; e.cyc = c;
    sb.push_back(e);
  endfunction

  // Monitor: compare on each rising edge of done, sampled at the falling clock edge.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
      end else begin
        e = sb.pop_front();
        chk(e.name, "pass",        64'(pass),        64'(e.pass));
        chk(e.name, "fail_code",   64'(fail_code),   64'(e.code));
        chk(e.name, "match_count", 64'(match_count), 64'(e.mc));
        chk(e.name, "fail_addr",   64'(fail_addr),   64'(e.fa));
        chk(e.name, "fail_data",   64'(fail_data),   64'(e.fd));
        chk(e.name, "cycle",       64'(cyc),         64'(e.cyc));
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input int na, input int tmo);
    num_active = 3'(na); timeout = TIMEOUT_W'(tmo); start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write = 1'b1; bus.data_adr = a; bus.write_data = d;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic wait_done(input string tn, input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    chk(tn, "done_reached", 64'(done), 64'(1));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear", "done", 64'(done), 64'(0));
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    num_active = '0; timeout = '0; start = 1'b0; clear = 1'b0;
    bus.mem_write = 1'b0; bus.data_adr = '0; bus.write_data = '0;
    #2;
    chk("reset", "done",        64'(done),        64'(0));
    chk("reset", "pass",        64'(pass),        64'(0));
    chk("reset", "fail_code",   64'(fail_code),   64'(0));
    chk("reset", "match_count", 64'(match_count), 64'(0));
    chk("reset", "fail_addr",   64'(fail_addr),   64'(0));
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single entry; writes to 96 only pass with the ignore window.
    cfg(0, 100, 7);
    go(1, 0);
`ifdef MEM_WRITE_CHECKER_IGNORE_EN
    wr(96, 3); wr(96, 5);
    push_exp("ign_pass", 1, 0, 1, 0, 0, cyc + 1);
    wr(100, 7);
`else
    push_exp("ign_fail", 0, 2, 0, 96, 3, cyc + 1);
    wr(96, 3); wr(96, 5); wr(100, 7);
    chk("sticky", "fail_addr", 64'(fail_addr), 64'(96));
`endif
    wait_done("t1", 10);
    do_clear();

    // Data mismatch, then a start while in FAIL is ignored.
    go(1, 0);
    push_exp("data_mm", 0, 1, 0, 100, 8, cyc + 1);
    wr(100, 8);
    wait_done("t2", 10);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_in_fail", "done",      64'(done),      64'(1));
    chk("start_in_fail", "fail_code", 64'(fail_code), 64'(1));
    do_clear();

    // Wrong address.
    go(1, 0);
    push_exp("addr_mm", 0, 2, 0, 104, 7, cyc + 1);
    wr(104, 7);
    wait_done("t3", 10);
    do_clear();

    go(1, 0);
`ifdef MEM_WRITE_CHECKER_IGNORE_EN
    wr(96, 1);
    push_exp("ign96_then_match", 1, 0, 1, 0, 0, cyc + 1);
    wr(100, 7);
`else
    push_exp("w96_fail", 0, 2, 0, 96, 1, cyc + 1);
    wr(96, 1);
`endif
    wait_done("t3b", 10);
    do_clear();

    // Order is enforced.
    cfg(1, 104, 9);
    go(2, 0);
    push_exp("order", 0, 2, 0, 104, 9, cyc + 1);
    wr(104, 9);
    wait_done("t4", 10);
    do_clear();

    // In-order pass; cfg_we during RUN must not alter entry 1.
    go(2, 0);
    cfg(1, 200, 1);
    wr(100, 7);
    push_exp("in_order", 1, 0, 2, 0, 0, cyc + 1);
    wr(104, 9);
    wait_done("t4b", 10);
    do_clear();

    // num_active 0 behaves as 1.
    go(0, 0);
    push_exp("na_zero", 1, 0, 1, 0, 0, cyc + 1);
    wr(100, 7);
    wait_done("t5", 10);
    do_clear();

    // num_active 7 clamps to 4.
    cfg(2, 108, 11);
    cfg(3, 112, 13);
    go(7, 0);
    wr(100, 7); wr(104, 9); wr(108, 11);
    push_exp("na_clamp", 1, 0, 4, 0, 0, cyc + 1);
    wr(112, 13);
    wait_done("t5b", 10);
    do_clear();

    // Timeout with no writes.
    go(1, 50);
    push_exp("timeout", 0, 3, 0, 0, 0, start_cyc + 50);
    wait_done("t6", 60);
    do_clear();

    // Write on the expiry cycle takes priority.
    go(1, 50);
    repeat (49) tick();
    push_exp("tmo_write_wins", 1, 0, 1, 0, 0, cyc + 1);
    wr(100, 7);
    wait_done("t7", 10);
    do_clear();

    // Reset in RUN after one of two matches.
    go(2, 0);
    wr(100, 7);
    chk("mid_run", "match_count", 64'(match_count), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset", "match_count", 64'(match_count), 64'(0));
    chk("mid_reset", "done",        64'(done),        64'(0));
    chk("mid_reset", "fail_code",   64'(fail_code),   64'(0));
    tick();
    reset = 1'b1;
    tick();

    // Table is cleared: entry 0 is (0,0).
    go(1, 0);
    push_exp("tbl_cleared", 1, 0, 1, 0, 0, cyc + 1);
    wr(0, 0);
    wait_done("t9", 10);
    do_clear();

    // cfg_we honoured again after reset.
    cfg(0, 100, 7);
    go(1, 0);
    push_exp("cfg_after_reset", 1, 0, 1, 0, 0, cyc + 1);
    wr(100, 7);
    wait_done("t9b", 10);
    do_clear();

    tick(); tick();
    chk("end", "scoreboard_left", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor. Sits on the CPU data-memory write port alongside the top-level core.
- Compares the stream of data-memory writes against a programmable ordered list of NUM_EXP expected (address, data) pairs.
- Reports pass, or fail with diagnostics. Includes a cycle timeout. Usable in simulation and on the FPGA board.

Parameters:
- ADDR_W, 32, address width of the monitored bus
- DATA_W, 32, data width of the monitored bus
- NUM_EXP, 4, depth of the expected-write table (≥1)
- TIMEOUT_W, 16, width of the timeout counter and of the timeout port
- IGN_LO, 96, lower bound (inclusive) of the ignored-address window
- IGN_HI, 96, upper bound (inclusive) of the ignored-address window

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_write  in  1  write strobe of the monitored bus
- data_adr  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- cfg_we  in  1  table write enable; honoured only in IDLE
- cfg_idx  in  $clog2(NUM_EXP)  table entry index
- cfg_addr  in  ADDR_W  expected address for the entry
- cfg_data  in  DATA_W  expected data for the entry
- num_active  in  $clog2(NUM_EXP+1)  number of entries to check (1..NUM_EXP), sampled on start
- timeout  in  TIMEOUT_W  cycle budget, sampled on start; 0 disables the timeout
- start  in  1  single-cycle pulse, IDLE→RUN
- clear  in  1  PASS/FAIL→IDLE
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS only
- fail_code  out  2  0 none, 1 data mismatch, 2 unexpected address, 3 timeout
- match_count  out  $clog2(NUM_EXP+1)  expected writes matched so far
- fail_addr  out  ADDR_W  address of the failing write
- fail_data  out  DATA_W  data of the failing write

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; table contents cleared to 0; cycle counter 0.
- States: IDLE, RUN, PASS, FAIL. All events are sampled at the rising clk edge; outputs are registered (1-cycle latency from the deciding write).
- IDLE:
  - cfg_we writes table[cfg_idx].
  - start: latch num_active (0 treated as 1; values >NUM_EXP clamp to NUM_EXP) and timeout; clear match_count, fail_* and the counter; go to RUN.
  - mem_write in IDLE, including the start cycle, is ignored.
- RUN: cfg_we ignored; counter increments every cycle. On mem_write with idx=match_count, evaluated in this priority:
  - data_adr==table[idx].addr and write_data==table[idx].data: match_count+1; if match_count+1==num_active → PASS.
  - data_adr==table[idx].addr and data differs: FAIL, code 1.
  - data_adr inside the ignore window (see Optional Feature): no effect.
  - otherwise: FAIL, code 2.
  - On any FAIL, fail_addr/fail_data capture the offending write.
- Timeout: if timeout≠0 and the counter reaches timeout with no mem_write in that cycle → FAIL, code 3, fail_addr/fail_data stay 0. A write in the same cycle takes priority over the timeout.
- PASS/FAIL: sticky; all further writes ignored; clear→IDLE with outputs zeroed, table retained. start here is ignored.
- Counter saturates; no wrap.
- Reset mid-RUN aborts immediately to IDLE.

Optional Feature:
- Macro MEM_WRITE_CHECKER_IGNORE_EN.
- Defined: writes with IGN_LO≤data_adr≤IGN_HI that do not match the current expected address are ignored (a matching address is still checked first).
- Undefined: no ignore window; every non-matching write fails with code 2. IGN_LO/IGN_HI are unused.

Decomposition:
- Package mem_write_checker_pkg holds:
  - state enum chk_state_t (IDLE, RUN, PASS, FAIL);
  - fail-code constants FAIL_NONE, FAIL_DATA, FAIL_ADDR, FAIL_TIMEOUT;
  - struct exp_entry_t {addr, data}, parametrised by width via the module.
- One natural sub-module: chk_timeout_counter, a saturating counter with enable, clear and an expiry compare.

Test Plan:
- Table {(100,7)}, num_active=1, timeout=0; writes (96,3),(96,5),(100,7) → pass=1, done=1, match_count=1 one cycle after the last write.
- Same table; write (100,8) → fail_code=1, fail_addr=100, fail_data=8, match_count=0.
- Same table; write (104,7) → fail_code=2 (with or without the macro); write (96,1) → fail_code=2 only when the macro is undefined.
- Table {(100,7),(104,9)}, num_active=2; writes (104,9) then (100,7) → FAIL code 2 on the first write (order enforced).
- timeout=50, no writes → fail_code=3 on the 50th cycle after start; a (100,7) write in that same cycle → PASS instead.
- In RUN after 1 of 2 matches, assert reset=0 → all outputs 0 immediately; after release, cfg_we is honoured and table entries are 0.
